// File: rtl/mmult_loader_if.sv
// Byte-stream handshake into the matrix loader.
// A transfer happens on a rising edge with in_valid and in_ready both high.
interface mmult_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/mmult_loader.sv
// Packs an 18-byte stream into the 3x3 A/B operands,
// then holds the multiplier enabled until the result is acked.
module mmult_loader (
  input  logic          clk,
  input  logic          reset_n,
  mmult_loader_if.slave in_if,
  input  logic          mult_valid,
  input  logic          result_ack,
  output logic [0:71]   A_mat,
  output logic [0:71]   B_mat,
  output logic          enable,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    HOLD   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [6:0] base;
  logic       loading;
  logic       xfer;
  logic       last;

  assign loading = (state == LOAD_A) || (state == LOAD_B);
  assign xfer    = in_if.in_valid && loading;
  assign last    = (cnt == 4'd8);
  assign base    = {cnt, 3'b000};

  // Handshake outputs depend on the state register only.
  assign in_if.in_ready = loading;
  assign enable         = (state == RUN) || (state == HOLD);
  assign busy           = !loading;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        state_nxt = LOAD_A;
        cnt_nxt   = 4'd0;
      end
      LOAD_A: begin
        if (xfer) begin
          if (last) begin
            state_nxt = LOAD_B;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (last) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      RUN: begin
        if (mult_valid) state_nxt = HOLD;
      end
      HOLD: begin
        if (result_ack) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = LOAD_A;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      A_mat <= '0;
      B_mat <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (xfer && state == LOAD_A)
        A_mat[base +: 8] <= in_if.in_data;
      if (xfer && state == LOAD_B)
        B_mat[base +: 8] <= in_if.in_data;
    end
  end

endmodule

// File: tb/tb_mmult_loader.sv
// Directed bench for mmult_loader with a 4-cycle
// registered 3x3 multiplier model on the output side.
module tb_mmult_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mult_valid;
  logic        result_ack;
  logic [0:71] A_mat;
  logic [0:71] B_mat;
  logic        enable;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  mmult_loader_if bus ();

  mmult_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_if      (bus.slave),
    .mult_valid (mult_valid),
    .result_ack (result_ack),
    .A_mat      (A_mat),
    .B_mat      (B_mat),
    .enable     (enable),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  localparam logic [0:71] ID_A = 72'h010000000100000001;
  localparam logic [0:71] ID_B = 72'h010203040506070809;
  localparam logic [0:71] ONES = {72{1'b1}};

  // multiplier model: valid 4 edges after enable rises
  int          mcnt;
  logic [17:0] c_mat [9];

  function automatic logic [17:0] mm_elem(int r, int c);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < 3; k++)
      s = s + 18'(A_mat[8*(3*r+k) +: 8]) * 18'(B_mat[8*(3*k+c) +: 8]);
    return s;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt       <= 0;
      mult_valid <= 1'b0;
    end else if (!enable) begin
      mcnt       <= 0;
      mult_valid <= 1'b0;
    end else if (mcnt < 4) begin
      mcnt <= mcnt + 1;
      if (mcnt == 3) begin
        mult_valid <= 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            c_mat[3*r+c] <= mm_elem(r, c);
      end
    end
  end

  task automatic send_job(input logic [0:71] a, input logic [0:71] b,
                          input bit bub, output int n_edges,
                          output logic en_before);
    int st;
    @(negedge clk);
    st = edge_cnt;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      if (bub && i > 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 9) ? a[8*i +: 8] : b[8*(i-9) +: 8];
      if (i == 17) en_before = enable;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_edges = edge_cnt - st;
  endtask

  task automatic wait_hold(output int e_hold);
    e_hold = -1;
    for (int k = 0; k < 20; k++) begin
      if (dut.state == ST_HOLD) begin
        e_hold = edge_cnt;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_job();
    repeat (8) @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    logic eb;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    result_ack   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl got en=%b rdy=%b busy=%b want 0 0 1",
               enable, bus.in_ready, busy);
    end
    checks++;
    if (A_mat !== '0 || B_mat !== '0) begin
      errors++;
      $display("FAIL reset_mats got A=%h B=%h want 0", A_mat, B_mat);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got rdy=%b busy=%b want 1 0",
               bus.in_ready, busy);
    end
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1 ||
        A_mat !== '0 || B_mat !== '0) begin
      errors++;
      $display("FAIL mid_reset got en=%b rdy=%b busy=%b A=%h B=%h",
               enable, bus.in_ready, busy, A_mat, B_mat);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_job(72'h112233445566778899, 72'hA1A2A3A4A5A6A7A8A9, 1'b0, n, eb);
    checks++;
    if (A_mat !== 72'h112233445566778899) begin
      errors++;
      $display("FAIL reload_A got %h want 112233445566778899", A_mat);
    end
    checks++;
    if (B_mat !== 72'hA1A2A3A4A5A6A7A8A9) begin
      errors++;
      $display("FAIL reload_B got %h want a1a2a3a4a5a6a7a8a9", B_mat);
    end
    finish_job();
  endtask

  task automatic test_identity();
    int n, e0, eh;
    logic eb;
    send_job(ID_A, ID_B, 1'b0, n, eb);
    e0 = edge_cnt;
    checks++;
    if (eb !== 1'b0 || enable !== 1'b1 || n != 18) begin
      errors++;
      $display("FAIL id_enable_rise got before=%b after=%b edges=%0d want 0 1 18",
               eb, enable, n);
    end
    checks++;
    if (A_mat !== ID_A || B_mat !== ID_B) begin
      errors++;
      $display("FAIL id_pack got A=%h B=%h", A_mat, B_mat);
    end
    wait_hold(eh);
    checks++;
    if (eh < 0 || eh - e0 != 5) begin
      errors++;
      $display("FAIL id_hold_lat got %0d want 5", eh < 0 ? -1 : eh - e0);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (c_mat[i] !== 18'(i + 1)) begin
        errors++;
        $display("FAIL id_C[%0d] got %0d want %0d", i, c_mat[i], i + 1);
      end
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL id_drain got en=%b rdy=%b want 0 0", enable, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL id_reload got en=%b rdy=%b want 0 1", enable, bus.in_ready);
    end
  endtask

  task automatic test_bubbles();
    int n;
    logic eb;
    send_job(ID_A, ID_B, 1'b1, n, eb);
    checks++;
    if (eb !== 1'b0 || enable !== 1'b1 || n != 35) begin
      errors++;
      $display("FAIL bub_enable got before=%b after=%b edges=%0d want 0 1 35",
               eb, enable, n);
    end
    checks++;
    if (A_mat !== ID_A || B_mat !== ID_B) begin
      errors++;
      $display("FAIL bub_pack got A=%h B=%h", A_mat, B_mat);
    end
    finish_job();
  endtask

  task automatic test_ack_order();
    int n;
    logic eb;
    send_job(ID_B, ID_A, 1'b0, n, eb);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (enable !== 1'b1 || dut.state !== ST_RUN) begin
      errors++;
      $display("FAIL ack_in_run got en=%b st=%0d want 1 3", enable, dut.state);
    end
    @(negedge clk);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (enable !== 1'b1 || dut.state !== ST_HOLD) begin
      errors++;
      $display("FAIL ack_with_valid got en=%b st=%0d want 1 4", enable, dut.state);
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ack_drain got en=%b rdy=%b want 0 0", enable, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_reload got en=%b rdy=%b want 0 1", enable, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, eh;
    logic eb;
    send_job(72'h0102030405060708F0, 72'h0908070605040302F1, 1'b0, n, eb);
    finish_job();
    send_job(ONES, ONES, 1'b0, n, eb);
    checks++;
    if (A_mat !== ONES || B_mat !== ONES) begin
      errors++;
      $display("FAIL b2b_pack got A=%h B=%h want all ff", A_mat, B_mat);
    end
    wait_hold(eh);
    checks++;
    if (eh < 0) begin
      errors++;
      $display("FAIL b2b_hold got timeout want HOLD");
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (c_mat[i] !== 18'h2FA03) begin
        errors++;
        $display("FAIL b2b_C[%0d] got %h want 2fa03", i, c_mat[i]);
      end
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    logic eb;
    logic [0:71] pa;
    logic [0:71] pb;
    pa = 72'h1F2E3D4C5B6A798897;
    pb = 72'h0123456789ABCDEF55;
    send_job(pa, pb, 1'b0, n, eb);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (A_mat !== pa || B_mat !== pb || dut.cnt !== 4'd0) begin
        errors++;
        $display("FAIL bp_frozen[%0d] got A=%h B=%h cnt=%0d", k, A_mat, B_mat,
                 dut.cnt);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0 + 8'(k);
      result_ack   = (k == 6);
      @(negedge clk);
    end
    result_ack = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || A_mat !== pa) begin
      errors++;
      $display("FAIL bp_release got rdy=%b A=%h want 1 %h", bus.in_ready, A_mat, pa);
    end
    bus.in_data = 8'h5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (A_mat !== {8'h5A, pa[8:71]} || dut.cnt !== 4'd1) begin
      errors++;
      $display("FAIL bp_first_byte got A=%h cnt=%0d want 5a in A[0] cnt 1",
               A_mat, dut.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bubbles();
    test_ack_order();
    test_back_to_back();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
